// File: rtl/bcd_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_mod_counter
//  Purpose  : Parametrised multi-digit BCD modulo counter. It counts tick
//             pulses up or down between decimal bounds MIN_VAL..MAX_VAL and
//             wraps around at either limit. A synchronous BCD load is
//             accepted only when the value is valid BCD and lies within the
//             bounds. The count is kept purely in BCD. There is no binary
//             shadow counter, and the limit checks compare packed BCD
//             vectors against constants that are converted at elaboration.
//
//  Ports    : ADC_CLK_10  in   system clock; all state changes on rising edge
//             reset       in   asynchronous active-low reset
//             tick        in   count enable, one step per high cycle
//             dir         in   count direction (1 = up, 0 = down)
//             load        in   synchronous load request (priority over tick)
//             load_val    in   BCD value to load, digit 0 in [3:0]
//             bcd         out  current count, packed BCD, digit 0 in [3:0]
//             wrap        out  one-cycle pulse when a step hits a limit
//             load_err    out  one-cycle pulse when a load was rejected
//
//  Options  : BCD_CNT_SATURATE_EN - when defined, steps at a limit leave the
//             count unchanged instead of wrapping. wrap still pulses.
//
//  Revision : 1.0  initial release
// ============================================================================
module bcd_mod_counter #(
   parameter int DIGITS  = 2,
   parameter int MIN_VAL = 1,
   parameter int MAX_VAL = 99
) (
   input  logic                ADC_CLK_10,
   input  logic                reset,
   input  logic                tick,
   input  logic                dir,
   input  logic                load,
   input  logic [4*DIGITS-1:0] load_val,
   output logic [4*DIGITS-1:0] bcd,
   output logic                wrap,
   output logic                load_err
);

   localparam int W = 4 * DIGITS;

   // ------------------------------------------------------------------------
   // Elaboration-time helpers
   // ------------------------------------------------------------------------
   function automatic int pow10(input int n);
      int r;
      r = 1;
      for (int i = 0; i < n; i++) begin
         r = r * 10;
      end
      return r;
   endfunction

   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r;
      int           t;
      r = '0;
      t = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t           = t / 10;
      end
      return r;
   endfunction

   localparam logic [W-1:0] MIN_BCD = to_bcd(MIN_VAL);
   localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_VAL);

   // Reject illegal configurations at elaboration rather than building a
   // counter whose limits cannot be represented.
   if (DIGITS < 1 || DIGITS > 6) begin : g_bad_digits
      $error("bcd_mod_counter: DIGITS must be 1..6");
   end
   else if (MIN_VAL < 0 || MIN_VAL >= MAX_VAL || MAX_VAL > pow10(DIGITS) - 1)
   begin : g_bad_range
      $error("bcd_mod_counter: need 0 <= MIN_VAL < MAX_VAL <= 10**DIGITS-1");
   end

   // ------------------------------------------------------------------------
   // Digit-wise increment / decrement and load validation
   // ------------------------------------------------------------------------
   // inc_carry[g] is set when every digit below g is 9, so digit g must
   // step. dec_borrow[g] is the same idea for digits at 0. Only DIGITS
   // entries are needed because nothing consumes the carry out of the top
   // digit. The limit checks intercept that case.
   logic [DIGITS-1:0] inc_carry;
   logic [DIGITS-1:0] dec_borrow;
   logic [DIGITS-1:0] nibble_ok;
   logic [W-1:0]      bcd_inc;
   logic [W-1:0]      bcd_dec;

   assign inc_carry[0]  = 1'b1;
   assign dec_borrow[0] = 1'b1;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      logic [3:0] d;
      assign d = bcd[4*g +: 4];

      assign bcd_inc[4*g +: 4] = !inc_carry[g] ? d :
                                 (d == 4'd9)   ? 4'd0 : d + 4'd1;
      assign bcd_dec[4*g +: 4] = !dec_borrow[g] ? d :
                                 (d == 4'd0)    ? 4'd9 : d - 4'd1;

      assign nibble_ok[g] = (load_val[4*g +: 4] <= 4'd9);

      if (g < DIGITS - 1) begin : g_chain
         assign inc_carry[g+1]  = inc_carry[g]  & (d == 4'd9);
         assign dec_borrow[g+1] = dec_borrow[g] & (d == 4'd0);
      end
   end

   // For valid BCD, an unsigned comparison of the packed vectors orders the
   // values in the same way as their decimal values. The range test is
   // therefore qualified by the nibble check.
   logic load_ok;
   logic at_max;
   logic at_min;

   assign load_ok = (&nibble_ok) && (load_val >= MIN_BCD) && (load_val <= MAX_BCD);
   assign at_max  = (bcd == MAX_BCD);
   assign at_min  = (bcd == MIN_BCD);

   // ------------------------------------------------------------------------
   // Count register and status pulses
   // ------------------------------------------------------------------------
   always_ff @(posedge ADC_CLK_10 or negedge reset) begin
      if (!reset) begin
         bcd      <= MIN_BCD;
         wrap     <= 1'b0;
         load_err <= 1'b0;
      end
      else begin
         wrap     <= 1'b0;
         load_err <= 1'b0;
         if (load) begin
            // A tick in the same cycle as a load is dropped.
            if (load_ok) begin
               bcd <= load_val;
            end
            else begin
               load_err <= 1'b1;
            end
         end
         else if (tick) begin
            if (dir) begin
               if (at_max) begin
                  wrap <= 1'b1;
`ifdef BCD_CNT_SATURATE_EN
                  bcd  <= bcd;
`else
                  bcd  <= MIN_BCD;
`endif
               end
               else begin
                  bcd <= bcd_inc;
               end
            end
            else begin
               if (at_min) begin
                  wrap <= 1'b1;
`ifdef BCD_CNT_SATURATE_EN
                  bcd  <= bcd;
`else
                  bcd  <= MAX_BCD;
`endif
               end
               else begin
                  bcd <= bcd_dec;
               end
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bcd_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_mod_counter
//  Purpose  : Self-checking bench for bcd_mod_counter. Unit A uses
//             (1..99) and unit B uses (1..31), both 2 digits. A decimal
//             integer model predicts every cycle. Predictions are queued when
//             stimulus is applied and compared once the edge has happened.
//             The build option BCD_CNT_SATURATE_EN is honoured by the model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bcd_mod_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       tick_a, dir_a, load_a, wrap_a, err_a;
   logic [7:0] lv_a, bcd_a;
   logic       tick_b, dir_b, load_b, wrap_b, err_b;
   logic [7:0] lv_b, bcd_b;

   bcd_mod_counter #(.DIGITS(2), .MIN_VAL(1), .MAX_VAL(99)) u_a (
      .ADC_CLK_10(clk), .reset(rst_n), .tick(tick_a), .dir(dir_a),
      .load(load_a), .load_val(lv_a), .bcd(bcd_a), .wrap(wrap_a),
      .load_err(err_a)
   );

   bcd_mod_counter #(.DIGITS(2), .MIN_VAL(1), .MAX_VAL(31)) u_b (
      .ADC_CLK_10(clk), .reset(rst_n), .tick(tick_b), .dir(dir_b),
      .load(load_b), .load_val(lv_b), .bcd(bcd_b), .wrap(wrap_b),
      .load_err(err_b)
   );

   int checks   = 0;
   int failures = 0;
   int val_a;
   int val_b;
   string cur_tag;

   typedef struct {
      string      tag;
      int         unit;
      logic [7:0] bcd;
      logic       wrap;
      logic       err;
   } exp_t;

   exp_t sb[$];

   function automatic logic [7:0] to_bcd2(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   // Decimal reference model of one clock edge.
   task automatic model(input int mn, input int mx, input logic t, input logic d,
                        input logic l, input logic [7:0] lv, input int v,
                        output int nv, output logic w, output logic e);
      int hi, lo;
      nv = v;
      w  = 1'b0;
      e  = 1'b0;
      if (!rst_n) begin
         nv = mn;
      end
      else if (l) begin
         hi = int'(lv[7:4]);
         lo = int'(lv[3:0]);
         if (hi <= 9 && lo <= 9 && (hi*10 + lo) >= mn && (hi*10 + lo) <= mx)
            nv = hi*10 + lo;
         else
            e = 1'b1;
      end
      else if (t) begin
         if (d) begin
            if (v == mx) begin
               w = 1'b1;
`ifndef BCD_CNT_SATURATE_EN
               nv = mn;
`endif
            end
            else nv = v + 1;
         end
         else begin
            if (v == mn) begin
               w = 1'b1;
`ifndef BCD_CNT_SATURATE_EN
               nv = mx;
`endif
            end
            else nv = v - 1;
         end
      end
   endtask

   task automatic compare(input exp_t e);
      logic [7:0] ob;
      logic       ow, oe;
      ob = (e.unit == 0) ? bcd_a  : bcd_b;
      ow = (e.unit == 0) ? wrap_a : wrap_b;
      oe = (e.unit == 0) ? err_a  : err_b;
      checks++;
      assert (ob === e.bcd) else begin
         failures++;
         $error("FAIL %s[u%0d] bcd observed=%h expected=%h", e.tag, e.unit, ob, e.bcd);
      end
      checks++;
      assert (ow === e.wrap) else begin
         failures++;
         $error("FAIL %s[u%0d] wrap observed=%b expected=%b", e.tag, e.unit, ow, e.wrap);
      end
      checks++;
      assert (oe === e.err) else begin
         failures++;
         $error("FAIL %s[u%0d] load_err observed=%b expected=%b", e.tag, e.unit, oe, e.err);
      end
   endtask

   // Predict both units for the inputs being driven, step one clock, and
   // then compare after the edge.
   task automatic step();
      exp_t e;
      int   nv;
      logic w, er;
      model(1, 99, tick_a, dir_a, load_a, lv_a, val_a, nv, w, er);
      val_a = nv;
      e.tag = cur_tag; e.unit = 0; e.bcd = to_bcd2(nv); e.wrap = w; e.err = er;
      sb.push_back(e);
      model(1, 31, tick_b, dir_b, load_b, lv_b, val_b, nv, w, er);
      val_b = nv;
      e.tag = cur_tag; e.unit = 1; e.bcd = to_bcd2(nv); e.wrap = w; e.err = er;
      sb.push_back(e);
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         compare(e);
      end
   endtask

   task automatic drive_b(input logic t, input logic d, input logic l, input logic [7:0] lv);
      tick_b = t; dir_b = d; load_b = l; lv_b = lv;
   endtask

   initial begin
      rst_n  = 1'b0;
      tick_a = 1'b0; dir_a = 1'b0; load_a = 1'b0; lv_a = 8'h00;
      tick_b = 1'b0; dir_b = 1'b0; load_b = 1'b0; lv_b = 8'h00;
      val_a  = 1;
      val_b  = 1;

      cur_tag = "reset_init";
      repeat (2) step();
      rst_n = 1'b1;

      // Unit A: count up through the digit carry to 99.
      cur_tag = "up_count";
      tick_a = 1'b1; dir_a = 1'b1;
      repeat (98) step();
      checks++;
      assert (bcd_a === 8'h99) else begin
         failures++;
         $error("FAIL up_reach_99 bcd observed=%h expected=99", bcd_a);
      end

      cur_tag = "up_wrap";
      step();
      cur_tag = "up_after_limit";
      repeat (2) step();
      tick_a = 1'b0;
      cur_tag = "wrap_clear";
      step();

      // Mid-count asynchronous reset with the tick still applied.
      tick_a = 1'b1;
      cur_tag = "pre_reset_count";
      repeat (5) step();
      rst_n = 1'b0;
      val_a = 1;
      val_b = 1;
      #1;
      checks++;
      assert (bcd_a === 8'h01) else begin
         failures++;
         $error("FAIL async_reset bcd observed=%h expected=01", bcd_a);
      end
      checks++;
      assert ({wrap_a, err_a} === 2'b00) else begin
         failures++;
         $error("FAIL async_reset flags observed=%b expected=00", {wrap_a, err_a});
      end
      cur_tag = "reset_held";
      repeat (3) step();
      rst_n  = 1'b1;
      tick_a = 1'b0;

      // Unit A: down wrap from MIN to MAX.
      cur_tag = "a_load01";
      load_a = 1'b1; lv_a = 8'h01;
      step();
      load_a = 1'b0; tick_a = 1'b1; dir_a = 1'b0;
      cur_tag = "a_down_wrap";
      step();
      tick_a = 1'b0;

      // Unit B: down count, borrow and wrap.
      cur_tag = "b_load10";   drive_b(1'b0, 1'b0, 1'b1, 8'h10); step();
      cur_tag = "b_borrow";   drive_b(1'b1, 1'b0, 1'b0, 8'h00); step();
      cur_tag = "b_load01";   drive_b(1'b0, 1'b0, 1'b1, 8'h01); step();
      cur_tag = "b_down_wrap"; drive_b(1'b1, 1'b0, 1'b0, 8'h00); step();
      cur_tag = "b_idle";     drive_b(1'b0, 1'b0, 1'b0, 8'h00); step();

      // Unit B: load validation.
      cur_tag = "b_load_1A";  drive_b(1'b0, 1'b0, 1'b1, 8'h1A); step();
      cur_tag = "b_load_32";  drive_b(1'b0, 1'b0, 1'b1, 8'h32); step();
      cur_tag = "b_load_00";  drive_b(1'b0, 1'b0, 1'b1, 8'h00); step();
      cur_tag = "b_load_25";  drive_b(1'b0, 1'b0, 1'b1, 8'h25); step();

      // A load takes priority over a coincident tick.
      cur_tag = "b_load_tick"; drive_b(1'b1, 1'b1, 1'b1, 8'h20); step();
      checks++;
      assert (bcd_b === 8'h20) else begin
         failures++;
         $error("FAIL load_over_tick bcd observed=%h expected=20", bcd_b);
      end
      cur_tag = "b_down_20";  drive_b(1'b1, 1'b0, 1'b0, 8'h00); repeat (2) step();
      cur_tag = "b_up_carry"; drive_b(1'b1, 1'b1, 1'b0, 8'h00); repeat (3) step();
      cur_tag = "b_hold";     drive_b(1'b0, 1'b0, 1'b0, 8'h00); step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
